// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its helpers.
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int DEFAULT_TIMEOUT = 32;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'b00,
        ARB_WAIT_ACCEPT = 2'b01,
        ARB_WAIT_DONE   = 2'b10
    } arb_state_e;

    // Watchdog width: must hold TIMEOUT-1, and is never narrower than 1 bit.
    function automatic int wdog_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from last+1, wrapping. Shared with the receive-side router.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int idx;

    // Walk the rotation from the far end so the nearest requester overwrites.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with start/accept/done tracking and a watchdog against a hung transmitter.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          sent,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_free,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    input  logic                        err_clr,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = wdog_width(TIMEOUT);

    arb_state_e          state, state_d;
    logic [WD_W-1:0]     wdog, wdog_d;
    logic [IDX_W-1:0]    last, last_d;
    logic [NUM_REQ-1:0]  ack_d, sent_d;
    logic [DATA_W-1:0]   tx_data_d;
    logic                tx_start_d, busy_d, err_d;
    logic [IDX_W-1:0]    grant_id_d;
    logic [IDX_W-1:0]    pick_winner;
    logic                pick_valid;
    logic                wdog_last, complete, expire;

    uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign wdog_last = (wdog == WD_W'(TIMEOUT - 1));

    // Next-state and registered-output decode; pulses default low each cycle.
    always_comb begin
        state_d    = state;
        wdog_d     = wdog;
        last_d     = last;
        ack_d      = '0;
        sent_d     = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        busy_d     = busy;
        grant_id_d = grant_id;
        complete   = 1'b0;
        expire     = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (tx_free && pick_valid) begin
                    tx_data_d           = req_data[pick_winner*DATA_W +: DATA_W];
                    grant_id_d          = pick_winner;
                    ack_d[pick_winner]  = 1'b1;
                    tx_start_d          = 1'b1;
                    busy_d              = 1'b1;
                    wdog_d              = '0;
                    state_d             = ARB_WAIT_ACCEPT;
                end
            end
            ARB_WAIT_ACCEPT: begin
                // A late-observed accept+finish still counts as completion.
                if (tx_done) begin
                    complete = 1'b1;
                end else if (!tx_free) begin
                    state_d = ARB_WAIT_DONE;
                    wdog_d  = '0;
                end else if (wdog_last) begin
                    expire = 1'b1;
                end else begin
                    wdog_d = wdog + 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_done) begin
                    complete = 1'b1;
                end else if (wdog_last) begin
                    expire = 1'b1;
                end else begin
                    wdog_d = wdog + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Completion and timeout both hand priority past the grantee.
        if (complete) begin
            sent_d[grant_id] = 1'b1;
            last_d           = grant_id;
            busy_d           = 1'b0;
            state_d          = ARB_IDLE;
        end
        if (expire) begin
            last_d  = grant_id;
            busy_d  = 1'b0;
            state_d = ARB_IDLE;
        end

        // A fresh timeout beats a simultaneous clear.
        err_d = expire ? 1'b1 : (err_clr ? 1'b0 : timeout_err);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= ARB_IDLE;
            wdog        <= '0;
            last        <= IDX_W'(NUM_REQ - 1);
            ack         <= '0;
            sent        <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            wdog        <= wdog_d;
            last        <= last_d;
            ack         <= ack_d;
            sent        <= sent_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            busy        <= busy_d;
            grant_id    <= grant_id_d;
            timeout_err <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int T       = 32;
    localparam int BIT_CYC = 2;

    logic         CLK;
    logic         reset;
    logic [N-1:0] req;
    logic [N*8-1:0] req_data;
    logic [N-1:0] ack, sent;
    logic [7:0]   tx_data;
    logic         tx_start, tx_free, tx_done, busy, err_clr, timeout_err;
    logic [1:0]   grant_id;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(8), .TIMEOUT(T)) dut (
        .CLK(CLK), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .sent(sent), .tx_data(tx_data), .tx_start(tx_start),
        .tx_free(tx_free), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
        .err_clr(err_clr), .timeout_err(timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // reference model: 0 idle, 1 granted/awaiting accept, 2 transmitting
    int         m_state, m_cnt, m_last, m_gid;
    logic [7:0] m_data;
    logic       m_busy, m_err;
    int         wait_cnt[N];
    logic [9:0] frames[$];
    logic [9:0] last_frame;
    bit         auto_tx, rnd_mode;

    // behavioural transmitter
    int         x_phase, x_lat, x_bit, x_sub;
    logic [9:0] x_fr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [N-1:0] e_ack, e_sent;
        logic e_start, to;
        int w;
        e_ack = '0; e_sent = '0; e_start = 1'b0; to = 1'b0;
        if (reset) begin
            m_state = 0; m_last = N - 1; m_err = 1'b0; m_gid = 0;
            m_data = 8'h00; m_busy = 1'b0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            frames.delete();
        end else begin
            for (int i = 0; i < N; i++) if (!req[i]) wait_cnt[i] = 0;
            if (m_state == 0) begin
                if (tx_free && req != '0) begin
                    w = pick(req, m_last);
                    for (int i = 0; i < N; i++) begin
                        if (i == w) wait_cnt[i] = 0;
                        else if (req[i]) begin
                            wait_cnt[i]++;
                            chk("fairness", 32'(wait_cnt[i] <= N - 1), 1);
                        end
                    end
                    m_gid = w; m_data = req_data[w*8 +: 8];
                    e_ack[w] = 1'b1; e_start = 1'b1; m_busy = 1'b1;
                    m_state = 1; m_cnt = 0;
                end
            end else begin
                if (tx_done) begin
                    e_sent[m_gid] = 1'b1; m_last = m_gid; m_busy = 1'b0; m_state = 0;
                    if (auto_tx) begin
                        if (frames.size() == 0) chk("frame_present", 0, 1);
                        else begin
                            last_frame = frames.pop_front();
                            chk("frame_bits", last_frame, {1'b1, m_data, 1'b0});
                        end
                    end
                end else if (m_state == 1 && !tx_free) begin
                    m_state = 2; m_cnt = 0;
                end else if (m_cnt == T - 1) begin
                    to = 1'b1; m_last = m_gid; m_busy = 1'b0; m_state = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (to) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        chk("ack", ack, e_ack);
        chk("sent", sent, e_sent);
        chk("tx_start", tx_start, e_start);
        chk("busy", busy, m_busy);
        chk("tx_data", tx_data, m_data);
        chk("grant_id", grant_id, m_gid);
        chk("timeout_err", timeout_err, m_err);
    endtask

    task automatic xmit_step();
        tx_done = 1'b0;
        case (x_phase)
            0: begin
                tx_free = 1'b1;
                if (tx_start) begin
                    x_lat = $urandom_range(0, 3); x_bit = 0; x_sub = 0;
                    if (x_lat == 0) begin tx_free = 1'b0; x_phase = 2; end
                    else x_phase = 1;
                end
            end
            1: begin
                x_lat--;
                if (x_lat == 0) begin tx_free = 1'b0; x_phase = 2; end
            end
            default: begin
                if (x_sub == 0)
                    x_fr[x_bit] = (x_bit == 0) ? 1'b0 : (x_bit == 9) ? 1'b1 : tx_data[x_bit-1];
                x_sub++;
                if (x_sub == BIT_CYC) begin
                    x_sub = 0; x_bit++;
                    if (x_bit == 10) begin
                        tx_done = 1'b1; tx_free = 1'b1;
                        frames.push_back(x_fr);
                        x_phase = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic rnd_req_step();
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i]) begin
                if ($urandom_range(0, 1) == 1) req_data[i*8 +: 8] = 8'($urandom);
                else req[i] = 1'b0;
            end else if (req[i]) begin
                if ($urandom_range(0, 99) < 3) req[i] = 1'b0;
            end else if ($urandom_range(0, 99) < 30) begin
                req[i] = 1'b1;
                req_data[i*8 +: 8] = 8'($urandom);
            end
        end
        err_clr = ($urandom_range(0, 9) == 0);
    endtask

    // One clock: sample after the edge, check, then update stimulus.
    task automatic cycle();
        @(posedge CLK);
        #1;
        model_check();
        if (auto_tx) xmit_step();
        if (rnd_mode) rnd_req_step();
    endtask

    task automatic do_reset();
        x_phase = 0; tx_done = 1'b0; tx_free = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int idx, input int budget);
        int n = 0;
        do begin cycle(); n++; end while (!ack[idx] && n < budget);
        chk("wait_ack", ack[idx], 1);
    endtask

    task automatic wait_sent(input int idx, input int budget);
        int n = 0;
        do begin cycle(); n++; end while (!sent[idx] && n < budget);
        chk("wait_sent", sent[idx], 1);
    endtask

    task automatic wait_any_ack(output int idx, input int budget);
        int n = 0;
        idx = -1;
        do begin cycle(); n++; end while (ack == '0 && n < budget);
        chk("wait_any_ack", 32'(ack != '0), 1);
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
    endtask

    initial begin
        int g;
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1; req = '0; req_data = '0; tx_free = 1'b1; tx_done = 1'b0;
        err_clr = 1'b0; auto_tx = 1'b0; rnd_mode = 1'b0; x_phase = 0;
        x_lat = 0; x_bit = 0; x_sub = 0; x_fr = '0; last_frame = '0;
        cycle(); cycle();
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // single requester, full frame through the transmitter model
        auto_tx = 1'b1;
        req = 4'b0001; req_data[7:0] = 8'hA5;
        wait_ack(0, 10);
        chk("t1_tx_data", tx_data, 8'hA5);
        req = '0;
        wait_sent(0, 60);
        chk("t1_frame", last_frame, 10'b1101001010);

        // round-robin with all requesters held
        do_reset();
        req = 4'hF; req_data = 32'h43322110;
        for (int k = 0; k < 5; k++) begin
            wait_any_ack(g, 60);
            chk("rr_order", g, rr_exp[k]);
            if (k == 4) req = '0;
        end
        wait_sent(0, 60);

        // contention raised while a grant is in flight
        do_reset();
        req = 4'b0100; req_data = 32'h44332211;
        wait_ack(2, 20);
        req = 4'b1010;
        wait_any_ack(g, 60);
        chk("contend_first", g, 3);
        req[3] = 1'b0;
        wait_any_ack(g, 60);
        chk("contend_second", g, 1);
        req = '0;
        wait_sent(1, 60);

        // watchdog: transmitter never accepts
        auto_tx = 1'b0;
        do_reset();
        req = 4'b0001; req_data[7:0] = 8'h5C;
        wait_ack(0, 5);
        req = '0;
        repeat (T - 1) cycle();
        chk("to_not_yet", timeout_err, 0);
        chk("to_busy_held", busy, 1);
        cycle();
        chk("to_err", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_no_sent", sent, 0);
        err_clr = 1'b1;
        cycle();
        chk("to_clr", timeout_err, 0);

        // timeout and clear in the same cycle: set wins
        req = 4'b0001;
        wait_ack(0, 5);
        req = '0;
        repeat (T) cycle();
        chk("to_set_wins", timeout_err, 1);
        cycle();
        chk("to_clr2", timeout_err, 0);
        err_clr = 1'b0;

        // completion coincident with expiry: completion wins
        req = 4'b0001;
        wait_ack(0, 5);
        req = '0;
        repeat (T - 1) cycle();
        tx_done = 1'b1;
        cycle();
        tx_done = 1'b0;
        chk("done_wins_sent", sent, 4'b0001);
        chk("done_wins_err", timeout_err, 0);

        // reset in the middle of a frame
        req = 4'b0001;
        wait_ack(0, 5);
        req = '0; tx_free = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_busy", busy, 0);
        chk("midrst_gid", grant_id, 0);
        chk("midrst_data", tx_data, 0);
        reset = 1'b0; tx_free = 1'b1;
        req = 4'b0110;
        wait_ack(1, 5);
        chk("midrst_first", grant_id, 1);
        req = '0; tx_done = 1'b1;
        cycle();
        tx_done = 1'b0;
        chk("midrst_sent", sent, 4'b0010);

        // transmitter busy when the request arrives
        tx_free = 1'b0; req = 4'b0001;
        repeat (5) begin
            cycle();
            chk("txbusy_no_ack", ack, 0);
            chk("txbusy_no_start", tx_start, 0);
        end
        tx_free = 1'b1;
        cycle();
        chk("txbusy_grant", ack, 4'b0001);
        req = '0; tx_done = 1'b1;
        cycle();
        tx_done = 1'b0;

        // random traffic against the transmitter model
        auto_tx = 1'b1;
        do_reset();
        rnd_mode = 1'b1;
        repeat (3000) cycle();
        rnd_mode = 1'b0; req = '0; err_clr = 1'b0;
        repeat (60) cycle();
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
